// File: rtl/sdrc_lite_init_ref_seq.sv
// rtl/sdrc_lite_init_ref_seq.sv - SDR SDRAM power-up init and auto-refresh sequencer (option: SDRC_LITE_REF_POSTPONE_EN)
//
// Power-up: WAIT, PALL, tRP, INIT_REF_NUM x (REF, tRFC), MRS, tMRD, then IDLE.
// Refresh:  the interval counter ticks every ref_intv_num clocks and marks a refresh as pending.
//           When the main FSM grants the bus, this block issues REF and holds the pins through tRFC.
//
// SDRC_LITE_REF_POSTPONE_EN defined:
//   - pending is a 4-bit count that saturates at 8;
//   - postponed refreshes are issued back to back.
// SDRC_LITE_REF_POSTPONE_EN undefined:
//   - pending is a single flag;
//   - a tick that finds the flag already set is lost and pulses ref_ovf.

module sdrc_lite_init_ref_seq #(
   parameter int SDR_A_W       = 12,
   parameter int SDR_BA_W      = 2,
   parameter int R_REF_I_CNT_W = 11,
   parameter int INIT_WAIT     = 20000,
   parameter int INIT_REF_NUM  = 2,
   parameter int CtRPm1        = 1,
   parameter int CtRFCm1       = 6,
   parameter int CtMRDm1       = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SDR_A_W-1:0]       mode_rg_val,
   input  logic [R_REF_I_CNT_W-1:0] ref_intv_num,
   input  logic                     ref_gnt,
   output logic                     init_done,
   output logic                     ref_req,
   output logic                     ref_busy,
   output logic                     ref_done,
`ifndef SDRC_LITE_REF_POSTPONE_EN
   output logic                     ref_ovf,
`endif
   output logic                     sdr_cs_n,
   output logic                     sdr_ras_n,
   output logic                     sdr_cas_n,
   output logic                     sdr_we_n,
   output logic [SDR_A_W-1:0]       sdr_a,
   output logic [SDR_BA_W-1:0]      sdr_ba
);

   // One wait counter serves the power-up wait and every tRP/tRFC/tMRD gap, so size it for the largest.
   localparam int WCNT_W = $clog2(INIT_WAIT + CtRPm1 + CtRFCm1 + CtMRDm1 + 2);
   localparam int IREF_W = $clog2(INIT_REF_NUM + 1);

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PALL = 4'b0010;
   localparam logic [3:0] CMD_REF  = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   // Precharge-all is signalled by A10 high.
   localparam logic [SDR_A_W-1:0] PALL_ADDR = SDR_A_W'(1024);

   typedef enum logic [3:0] {
      ST_WAIT,
      ST_PALL,
      ST_TRP,
      ST_IREF,
      ST_ITRFC,
      ST_MRS,
      ST_TMRD,
      ST_IDLE,
      ST_AREF,
      ST_ATRFC
   } state_t;

   state_t                   state;
   logic [WCNT_W-1:0]        wcnt;
   logic [IREF_W-1:0]        iref_left;
   logic [R_REF_I_CNT_W-1:0] ref_cnt;
   logic                     init_last;
   logic                     ref_tick;
   logic                     ref_issue;
   logic                     pend_nz;

`ifdef SDRC_LITE_REF_POSTPONE_EN
   logic [3:0] pending;
`else
   logic       pending;
`endif

   // Last tMRD cycle: the interval counter starts counting on this edge, together with init_done rising.
   assign init_last = ((state == ST_MRS) || (state == ST_TMRD)) && (wcnt == '0);

   // Wrap of the refresh interval counter.
   assign ref_tick  = init_done && (ref_cnt == (ref_intv_num - R_REF_I_CNT_W'(1)));

   assign pend_nz   = (pending != '0);
   assign ref_req   = pend_nz && (state == ST_IDLE) && init_done;

   // A grant counts only while a refresh is being requested.
   assign ref_issue = ref_req && ref_gnt;

   // Sequencer FSM: state, wait counter and all registered command/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_WAIT;
         wcnt      <= WCNT_W'(INIT_WAIT - 1);
         iref_left <= '0;
         init_done <= 1'b0;
         ref_busy  <= 1'b1;
         ref_done  <= 1'b0;
         {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
         sdr_a     <= '0;
         sdr_ba    <= '0;
      end else begin
         // Each command is a one-cycle pulse; NOP with zero address otherwise.
         {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
         sdr_a    <= '0;
         sdr_ba   <= '0;
         ref_done <= 1'b0;

         case (state)
            ST_WAIT: begin
               if (wcnt == '0) begin
                  state <= ST_PALL;
                  {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_PALL;
                  sdr_a <= PALL_ADDR;
                  wcnt  <= WCNT_W'(CtRPm1);
               end else begin
                  wcnt <= wcnt - WCNT_W'(1);
               end
            end

            ST_PALL, ST_TRP: begin
               if (wcnt == '0) begin
                  state     <= ST_IREF;
                  {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_REF;
                  wcnt      <= WCNT_W'(CtRFCm1);
                  iref_left <= IREF_W'(INIT_REF_NUM - 1);
               end else begin
                  state <= ST_TRP;
                  wcnt  <= wcnt - WCNT_W'(1);
               end
            end

            ST_IREF, ST_ITRFC: begin
               if (wcnt == '0) begin
                  if (iref_left == '0) begin
                     state  <= ST_MRS;
                     {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_MRS;
                     sdr_a  <= mode_rg_val;
                     sdr_ba <= '0;
                     wcnt   <= WCNT_W'(CtMRDm1);
                  end else begin
                     state     <= ST_IREF;
                     {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_REF;
                     wcnt      <= WCNT_W'(CtRFCm1);
                     iref_left <= iref_left - IREF_W'(1);
                  end
               end else begin
                  state <= ST_ITRFC;
                  wcnt  <= wcnt - WCNT_W'(1);
               end
            end

            ST_MRS, ST_TMRD: begin
               if (wcnt == '0) begin
                  state     <= ST_IDLE;
                  init_done <= 1'b1;
                  ref_busy  <= 1'b0;
               end else begin
                  state <= ST_TMRD;
                  wcnt  <= wcnt - WCNT_W'(1);
               end
            end

            ST_IDLE: begin
               if (ref_issue) begin
                  state    <= ST_AREF;
                  {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_REF;
                  ref_busy <= 1'b1;
               end
            end

            // The REF cycle itself is followed by a full CtRFCm1+1 cycles of tRFC.
            ST_AREF: begin
               state    <= ST_ATRFC;
               wcnt     <= WCNT_W'(CtRFCm1);
               ref_done <= (CtRFCm1 == 0);
            end

            ST_ATRFC: begin
               if (wcnt == '0) begin
                  state    <= ST_IDLE;
                  ref_busy <= 1'b0;
               end else begin
                  wcnt     <= wcnt - WCNT_W'(1);
                  ref_done <= (wcnt == WCNT_W'(1));
               end
            end

            default: begin
               state <= ST_WAIT;
               wcnt  <= WCNT_W'(INIT_WAIT - 1);
            end
         endcase
      end
   end

   // Refresh interval counter: held at zero until init completes, then 0..ref_intv_num-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt <= '0;
      end else if (init_done || init_last) begin
         ref_cnt <= ref_tick ? '0 : ref_cnt + R_REF_I_CNT_W'(1);
      end else begin
         ref_cnt <= '0;
      end
   end

`ifdef SDRC_LITE_REF_POSTPONE_EN
   // Pending refresh count: a tick adds one (up to 8), an issue removes one, and both together cancel.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         case ({ref_tick, ref_issue})
            2'b10: begin
               if (pending != 4'd8) begin
                  pending <= pending + 4'd1;
               end
            end
            2'b01:   pending <= pending - 4'd1;
            default: pending <= pending;
         endcase
      end
   end
`else
   // Pending refresh flag: a tick that finds it already set is lost and reported on ref_ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         ref_ovf <= 1'b0;
      end else begin
         ref_ovf <= 1'b0;
         case ({ref_tick, ref_issue})
            2'b10: begin
               if (pending) begin
                  ref_ovf <= 1'b1;
               end else begin
                  pending <= 1'b1;
               end
            end
            2'b01:   pending <= 1'b0;
            default: pending <= pending;
         endcase
      end
   end
`endif

endmodule
